stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  Timebase and control for the stopwatch. Divides the board clock to a 1 Hz
//  tick and runs a start/stop/clear state machine. Accumulates elapsed seconds
//  into a 13-bit count that feeds the MM:SS display stage directly.
//  Button inputs are raw (already debounced) levels. This block synchronises them and edge-detects them.
// PARAMETERS
//  TICK_DIV   100_000_000  clk cycles per second tick (>=2)
//  MAX_COUNT  5999         last count value (99:59); next tick wraps to 0
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  btn_start  in   1   start/stop toggle, async level, debounced
//  btn_clear  in   1   clear, async level, debounced
//  count      out  13  elapsed seconds, 0..MAX_COUNT
//  running    out  1   1 while in RUNNING
//  tick       out  1   one-cycle pulse on each counted second
//  wrapped    out  1   sticky; set when count wraps MAX_COUNT->0
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, count=0, prescaler=0, tick=0,
//   running=0, wrapped=0. All sync/edge flops are 0.
//  Input sync: each button passes through 2 flops (s1,s2), plus a history flop s3.
//   press = s2 & ~s3. A level rising before edge N is acted on at edge N+2.
//   Holding a button gives one press only.
//  States: IDLE, RUNNING, PAUSED (2-bit encoding).
//   IDLE   : start press -> RUNNING
//   RUNNING: start press -> PAUSED
//   PAUSED : start press -> RUNNING
//   any    : clear press -> IDLE
//  Clear effects: count=0, prescaler=0, wrapped=0.
//   Clear has priority over start and tick in the same cycle.
//  Prescaler: counts 0..TICK_DIV-1 only in RUNNING. It holds its value in PAUSED,
//   so the sub-second fraction is kept across a pause. It is 0 in IDLE.
//  tick: registered. It is 1 in the cycle after the edge where prescaler==TICK_DIV-1
//   in RUNNING. The prescaler returns to 0 at that same edge.
//   count increments at the same edge tick rises, so count and tick change together.
//  Count: it increments by 1 on each tick. At MAX_COUNT the next tick loads 0 and
//   sets wrapped. Width arithmetic is unsigned 13-bit. count never exceeds MAX_COUNT.
//  Stop on terminal cycle: a start press at the edge where prescaler==TICK_DIV-1
//   moves to PAUSED, and the tick is NOT issued. The prescaler holds TICK_DIV-1.
//   After resume, the tick fires at the first RUNNING edge.
//  running = (state==RUNNING), registered with state.
//  count, running, wrapped change only on clk edges or async reset. They are glitch-free.
//  Reset asserted mid-run: all outputs reach reset values immediately. No tick is
//   emitted after release until a new start press plus TICK_DIV cycles.
// TESTING  (TICK_DIV=4, MAX_COUNT=5999 unless noted)
//  1 Reset, then start pulse -> running=1 at edge+2. First tick 4 cycles later.
//    count=1,2,3 every 4 cycles.
//  2 Run to count=3, press start -> running=0, count holds 3 for 50 cycles.
//    Press start -> tick resumes with the saved fraction. count=4.
//  3 Force count to 5999 via run (MAX_COUNT=5). Tick at 5 -> count=0, wrapped=1.
//    Clear -> wrapped=0.
//  4 btn_start and btn_clear rise in the same cycle while RUNNING -> state IDLE,
//    count=0, running=0.
//  5 btn_start held high for 100 cycles -> exactly one state toggle.
//  6 rst_n low mid-cycle while count=7 -> count=0, running=0 before next clk edge.
//    No tick for 4+ cycles after release.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch timebase: synchronises and edge-detects the buttons, divides clk down
// to a one-second tick and runs the IDLE/RUNNING/PAUSED control with a wrapping seconds count.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned MAX_COUNT = 5999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic [12:0] count,
  output logic        running,
  output logic        tick,
  output logic        wrapped
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [12:0]   COUNT_LAST = 13'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [2:0]    start_sync;
  logic [2:0]    clear_sync;
  logic          start_press;
  logic          clear_press;

  // Two synchroniser stages plus a history stage; a press is the rising edge seen at stage two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= 3'b000;
      clear_sync <= 3'b000;
    end else begin
      start_sync <= {start_sync[1:0], btn_start};
      clear_sync <= {clear_sync[1:0], btn_clear};
    end
  end

  assign start_press = start_sync[1] & ~start_sync[2];
  assign clear_press = clear_sync[1] & ~clear_sync[2];

  // Clear beats start beats tick; a start press on the terminal prescaler cycle swallows that tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      count     <= '0;
      running   <= 1'b0;
      tick      <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear_press) begin
        state     <= IDLE;
        running   <= 1'b0;
        prescaler <= '0;
        count     <= '0;
        wrapped   <= 1'b0;
      end else if (start_press) begin
        case (state)
          IDLE, PAUSED: begin
            state   <= RUNNING;
            running <= 1'b1;
          end
          RUNNING: begin
            state   <= PAUSED;
            running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end else if (state == RUNNING) begin
        if (prescaler == PRE_LAST) begin
          prescaler <= '0;
          tick      <= 1'b1;
          if (count >= COUNT_LAST) begin
            count   <= '0;
            wrapped <= 1'b1;
          end else begin
            count <= count + 13'd1;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (full-range and MAX_COUNT=5) driven in parallel,
// checked every cycle against a seconds/fraction model plus directed literal expectations.
module tb_stopwatch_counter;

  localparam int TICK_DIV = 4;
  localparam int MAX_A    = 5999;
  localparam int MAX_B    = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_clear = 1'b0;
  logic [12:0] count_a, count_b;
  logic        running_a, running_b;
  logic        tick_a, tick_b;
  logic        wrapped_a, wrapped_b;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  stopwatch_counter #(.TICK_DIV(TICK_DIV), .MAX_COUNT(MAX_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
    .count(count_a), .running(running_a), .tick(tick_a), .wrapped(wrapped_a)
  );

  stopwatch_counter #(.TICK_DIV(TICK_DIV), .MAX_COUNT(MAX_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
    .count(count_b), .running(running_b), .tick(tick_b), .wrapped(wrapped_b)
  );

  always #5 clk = ~clk;

  // mode: 0 idle, 1 running, 2 paused; frac counts clocks into the current second
  typedef struct {
    int mode;
    int frac;
    int secs;
    bit wrap;
    bit tk;
  } model_t;

  model_t ma, mb;
  bit sb1, sb2, sb3, cb1, cb2, cb3;

  function automatic model_t model_step(model_t m, bit sp, bit cp, int max_secs);
    model_t r = m;
    r.tk = 1'b0;
    if (cp) begin
      r.mode = 0;
      r.frac = 0;
      r.secs = 0;
      r.wrap = 1'b0;
    end else if (sp) begin
      r.mode = (m.mode == 1) ? 2 : 1;
    end else if (m.mode == 1) begin
      r.frac = m.frac + 1;
      if (r.frac == TICK_DIV) begin
        r.frac = 0;
        r.tk = 1'b1;
        r.secs = (m.secs + 1) % (max_secs + 1);
        if (r.secs == 0) r.wrap = 1'b1;
      end
    end
    return r;
  endfunction

  // A level seen before edge k-2 but not before edge k-3 is a press acted on at edge k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = '{0, 0, 0, 1'b0, 1'b0};
      mb = '{0, 0, 0, 1'b0, 1'b0};
      {sb1, sb2, sb3, cb1, cb2, cb3} = 6'b0;
    end else begin
      ma = model_step(ma, sb2 & ~sb3, cb2 & ~cb3, MAX_A);
      mb = model_step(mb, sb2 & ~sb3, cb2 & ~cb3, MAX_B);
      sb3 = sb2; sb2 = sb1; sb1 = btn_start;
      cb3 = cb2; cb2 = cb1; cb1 = btn_clear;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output();
    check("model_count_a",   int'(count_a),   ma.secs);
    check("model_running_a", int'(running_a), int'(ma.mode == 1));
    check("model_tick_a",    int'(tick_a),    int'(ma.tk));
    check("model_wrapped_a", int'(wrapped_a), int'(ma.wrap));
    check("model_count_b",   int'(count_b),   mb.secs);
    check("model_running_b", int'(running_b), int'(mb.mode == 1));
    check("model_tick_b",    int'(tick_b),    int'(mb.tk));
    check("model_wrapped_b", int'(wrapped_b), int'(mb.wrap));
  endtask

  always @(negedge clk) begin
    if (checking) check_output();
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input bit start, input bit clear);
    btn_start = start;
    btn_clear = clear;
    step(1);
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    checking = 1'b1;
    check("reset_count",   int'(count_a),   0);
    check("reset_running", int'(running_a), 0);
    check("reset_tick",    int'(tick_a),    0);
    check("reset_wrapped", int'(wrapped_b), 0);
    step(2);
    rst_n = 1'b1;

    // start latency and first ticks
    apply_stimulus(1'b1, 1'b0);
    step(1);
    check("start_not_yet", int'(running_a), 0);
    step(1);
    check("start_running", int'(running_a), 1);
    step(3);
    check("no_early_tick", int'(tick_a), 0);
    step(1);
    check("first_tick", int'(tick_a), 1);
    check("count_1", int'(count_a), 1);
    step(4);
    check("count_2", int'(count_a), 2);
    step(4);
    check("count_3", int'(count_a), 3);

    // pause keeps count and fraction
    apply_stimulus(1'b1, 1'b0);
    step(2);
    check("paused", int'(running_a), 0);
    step(50);
    check("pause_hold", int'(count_a), 3);
    apply_stimulus(1'b1, 1'b0);
    step(3);
    check("resume_before_tick", int'(count_a), 3);
    step(1);
    check("resume_tick", int'(tick_a), 1);
    check("resume_count", int'(count_a), 4);

    // wrap on the short instance, then clear
    step(4);
    check("count_b_5", int'(count_b), 5);
    step(4);
    check("wrap_count_b", int'(count_b), 0);
    check("wrap_flag_b", int'(wrapped_b), 1);
    check("count_a_6", int'(count_a), 6);
    check("no_wrap_a", int'(wrapped_a), 0);
    apply_stimulus(1'b0, 1'b1);
    step(2);
    check("clear_wrapped", int'(wrapped_b), 0);
    check("clear_count", int'(count_a), 0);
    check("clear_running", int'(running_a), 0);

    // simultaneous start and clear while running
    apply_stimulus(1'b1, 1'b0);
    step(10);
    check("run_again", int'(running_a), 1);
    check("count_before_both", int'(count_a), 2);
    apply_stimulus(1'b1, 1'b1);
    step(2);
    check("both_running", int'(running_a), 0);
    check("both_count", int'(count_a), 0);

    // async reset in the middle of a cycle
    apply_stimulus(1'b1, 1'b0);
    step(30);
    check("count_7", int'(count_a), 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_count", int'(count_a), 0);
    check("async_running", int'(running_a), 0);
    check("async_tick", int'(tick_a), 0);
    check("async_wrapped", int'(wrapped_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("post_reset_tick", int'(tick_a), 0);
    end

    // held start toggles once; then a pause on the terminal cycle
    btn_start = 1'b1;
    step(100);
    check("hold_one_toggle", int'(running_a), 1);
    btn_start = 1'b0;
    step(8);
    apply_stimulus(1'b1, 1'b0);
    step(2);
    check("terminal_pause", int'(running_a), 0);
    check("terminal_no_tick", int'(tick_a), 0);
    check("terminal_count", int'(count_a), 26);
    apply_stimulus(1'b1, 1'b0);
    step(2);
    check("terminal_resume", int'(running_a), 1);
    check("terminal_resume_count", int'(count_a), 26);
    step(1);
    check("terminal_tick", int'(tick_a), 1);
    check("terminal_tick_count", int'(count_a), 27);

    step(3);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
